// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size codes and decode helpers for the LSU bus front-end
package lsu_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AWW,
      ST_B,
      ST_RESP
   } state_t;

   function automatic logic [3:0] strb_base(input logic [1:0] size);
      case (size)
         SZ_B:    return 4'b0001;
         SZ_H:    return 4'b0011;
         SZ_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Size 3 is reported as misaligned so the FSM has a single error path.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         SZ_W:    return |addr_lo;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// rtl/lsu_axi_master_if.sv - AXI-lite bus between the LSU master and the data SRAM slave
interface lsu_axi_master_if;
   import lsu_pkg::*;

   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, input arready,
      input rdata, rresp, rvalid, output rready,
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready
   );

   modport slave (
      input araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready,
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready
   );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]          st_addr_lo,
   input  logic [1:0]          st_size,
   input  logic [DATA_W-1:0]   st_data,
   output logic [DATA_W-1:0]   st_wdata,
   output logic [DATA_W/8-1:0] st_wstrb,
   input  logic [1:0]          ld_addr_lo,
   input  logic [1:0]          ld_size,
   input  logic                ld_unsigned,
   input  logic [DATA_W-1:0]   ld_rdata,
   output logic [DATA_W-1:0]   ld_data
);

   logic [DATA_W-1:0] ld_shift;

   always_comb begin
      st_wdata = st_data << {st_addr_lo, 3'b000};
      st_wstrb = strb_base(st_size) << st_addr_lo;
      ld_shift = ld_rdata >> {ld_addr_lo, 3'b000};
      case (ld_size)
         SZ_B:    ld_data = {{(DATA_W-8){~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
         SZ_H:    ld_data = {{(DATA_W-16){~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding LSU request to AXI-lite transaction FSM
module lsu_axi_master
   import lsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   lsu_axi_master_if.master  axi
);

   state_t                state_q, state_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic [ADDR_W-1:0]     araddr_q, araddr_d;
   logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;

   logic [DATA_W-1:0]     st_wdata;
   logic [DATA_W/8-1:0]   st_wstrb;
   logic [DATA_W-1:0]     ld_data;
   logic                  aw_now, w_now;

   // Store lanes are computed from the incoming request; load lanes from the registered one.
   lsu_align u_align (
      .st_addr_lo  (req_addr[1:0]),
      .st_size     (req_size),
      .st_data     (req_wdata),
      .st_wdata    (st_wdata),
      .st_wstrb    (st_wstrb),
      .ld_addr_lo  (addr_lo_q),
      .ld_size     (size_q),
      .ld_unsigned (uns_q),
      .ld_rdata    (axi.rdata),
      .ld_data     (ld_data)
   );

   always_comb begin
      state_d      = state_q;
      addr_lo_d    = addr_lo_q;
      size_d       = size_q;
      uns_d        = uns_q;
      araddr_d     = araddr_q;
      awaddr_d     = awaddr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      aw_now       = aw_done_q | axi.awready;
      w_now        = w_done_q | axi.wready;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_lo_d    = req_addr[1:0];
               size_d       = req_size;
               uns_d        = req_unsigned;
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  resp_err_d = 1'b1;
                  state_d    = ST_RESP;
               end else if (req_we) begin
                  awaddr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  wdata_d  = st_wdata;
                  wstrb_d  = st_wstrb;
                  state_d  = ST_AWW;
               end else begin
                  araddr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  state_d  = ST_AR;
               end
            end
         end
         ST_AR: begin
            if (axi.arready) state_d = ST_R;
         end
         ST_R: begin
            if (axi.rvalid) begin
               resp_err_d   = |axi.rresp;
               resp_rdata_d = (|axi.rresp) ? '0 : ld_data;
               state_d      = ST_RESP;
            end
         end
         ST_AWW: begin
            aw_done_d = aw_now;
            w_done_d  = w_now;
            if (aw_now && w_now) state_d = ST_B;
         end
         ST_B: begin
            if (axi.bvalid) begin
               resp_err_d = |axi.bresp;
               state_d    = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         addr_lo_q    <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         araddr_q     <= '0;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_lo_q    <= addr_lo_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         araddr_q     <= araddr_d;
         awaddr_q     <= awaddr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign resp_valid  = (state_q == ST_RESP);
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;

   assign axi.araddr  = araddr_q;
   assign axi.arvalid = (state_q == ST_AR);
   assign axi.rready  = (state_q == ST_R);
   assign axi.awaddr  = awaddr_q;
   assign axi.awvalid = (state_q == ST_AWW) && !aw_done_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wvalid  = (state_q == ST_AWW) && !w_done_q;
   assign axi.bready  = (state_q == ST_B);

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - directed self-checking bench for lsu_axi_master
module tb_lsu_axi_master;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_axi_master_if axi();

   lsu_axi_master dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .axi          (axi)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
      resp_ready = 0;
      axi.arready = 0; axi.rdata = 0; axi.rresp = 0; axi.rvalid = 0;
      axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
   endtask

   task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input logic uns);
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_size = size; req_unsigned = uns;
   endtask

   // Issues a load from IDLE and plays the slave; returns with the DUT sitting in RESP.
   task automatic load_txn(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rd, input logic [1:0] rr,
                           input int ar_dly, input int r_dly,
                           output logic [31:0] ar_seen, output bit ar_stable, output bit lat_ok);
      @(negedge clk);
      drive_req(1'b0, addr, 32'h0, size, uns);
      @(negedge clk);
      req_valid = 0;
      lat_ok    = (axi.arvalid === 1'b1);
      ar_seen   = axi.araddr;
      ar_stable = 1;
      repeat (ar_dly) begin
         @(negedge clk);
         if (axi.arvalid !== 1'b1 || axi.araddr !== ar_seen) ar_stable = 0;
      end
      axi.arready = 1;
      @(negedge clk);
      axi.arready = 0;
      if (axi.arvalid !== 1'b0 || axi.rready !== 1'b1) lat_ok = 0;
      repeat (r_dly) begin
         @(negedge clk);
         if (axi.rready !== 1'b1 || axi.araddr !== ar_seen) ar_stable = 0;
      end
      if (axi.araddr !== ar_seen) ar_stable = 0;
      axi.rvalid = 1; axi.rdata = rd; axi.rresp = rr;
      @(negedge clk);
      axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
      if (resp_valid !== 1'b1 || axi.rready !== 1'b0) lat_ok = 0;
   endtask

   task automatic consume_resp(output logic rv_after, output logic rr_after);
      resp_ready = 1;
      @(negedge clk);
      resp_ready = 0;
      rv_after = resp_valid;
      rr_after = req_ready;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      n_checks++;
      if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, resp_valid} !== 6'b0) begin
         n_fail++; $display("FAIL reset_valids: got %b expected 000000",
            {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, resp_valid});
      end
      n_checks++;
      if ({axi.araddr, axi.awaddr, axi.wdata, axi.wstrb, resp_rdata, resp_err} !== 133'b0) begin
         n_fail++; $display("FAIL reset_data: araddr %h awaddr %h wdata %h wstrb %b rdata %h err %b expected all 0",
            axi.araddr, axi.awaddr, axi.wdata, axi.wstrb, resp_rdata, resp_err);
      end
   endtask

   task automatic test_word_load();
      logic [31:0] ar_seen; bit stable, lat; logic rv, rr;
      load_txn(32'h8000_0004, SZ_W, 1'b0, 32'hDEAD_BEEF, 2'b00,
               $urandom_range(0, 3), $urandom_range(0, 3), ar_seen, stable, lat);
      n_checks++;
      if (lat !== 1'b1) begin n_fail++; $display("FAIL word_load_latency: got %b expected 1", lat); end
      n_checks++;
      if (ar_seen !== 32'h8000_0004) begin n_fail++; $display("FAIL word_load_araddr: got %h expected 80000004", ar_seen); end
      n_checks++;
      if (stable !== 1'b1) begin n_fail++; $display("FAIL word_load_araddr_stable: got %b expected 1", stable); end
      n_checks++;
      if ({resp_rdata, resp_err} !== {32'hDEAD_BEEF, 1'b0}) begin
         n_fail++; $display("FAIL word_load_resp: got %h/%b expected deadbeef/0", resp_rdata, resp_err);
      end
      consume_resp(rv, rr);
      n_checks++;
      if ({rv, rr} !== 2'b01) begin n_fail++; $display("FAIL word_load_release: got valid/ready %b%b expected 01", rv, rr); end
   endtask

   task automatic test_byte_load();
      logic [31:0] ar_seen; bit stable, lat; logic rv, rr;
      load_txn(32'h8000_0003, SZ_B, 1'b0, 32'h80AA_BBCC, 2'b00, 0, 1, ar_seen, stable, lat);
      n_checks++;
      if (ar_seen !== 32'h8000_0000) begin n_fail++; $display("FAIL byte_load_araddr: got %h expected 80000000", ar_seen); end
      n_checks++;
      if (resp_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_load_signed: got %h expected ffffff80", resp_rdata); end
      consume_resp(rv, rr);
      load_txn(32'h8000_0003, SZ_B, 1'b1, 32'h80AA_BBCC, 2'b00, 1, 0, ar_seen, stable, lat);
      n_checks++;
      if ({resp_rdata, resp_err} !== {32'h0000_0080, 1'b0}) begin
         n_fail++; $display("FAIL byte_load_unsigned: got %h/%b expected 00000080/0", resp_rdata, resp_err);
      end
      consume_resp(rv, rr);
   endtask

   task automatic test_half_store();
      logic rv, rr;
      @(negedge clk);
      drive_req(1'b1, 32'h8000_0002, 32'h0000_1234, SZ_H, 1'b0);
      @(negedge clk);
      req_valid = 0;
      n_checks++;
      if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb} !== {2'b11, 32'h8000_0000, 32'h1234_0000, 4'b1100}) begin
         n_fail++; $display("FAIL half_store_bus: got aw/w %b%b awaddr %h wdata %h wstrb %b expected 11 80000000 12340000 1100",
            axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb);
      end
      axi.awready = 1;
      @(negedge clk);
      axi.awready = 0;
      n_checks++;
      if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b010) begin
         n_fail++; $display("FAIL half_store_aw_only: got aw/w/b %b expected 010", {axi.awvalid, axi.wvalid, axi.bready});
      end
      axi.wready = 1;
      @(negedge clk);
      axi.wready = 0;
      n_checks++;
      if ({axi.wvalid, axi.bready, axi.wdata, axi.awaddr} !== {2'b01, 32'h1234_0000, 32'h8000_0000}) begin
         n_fail++; $display("FAIL half_store_b_wait: got w/b %b%b wdata %h awaddr %h expected 01 12340000 80000000",
            axi.wvalid, axi.bready, axi.wdata, axi.awaddr);
      end
      axi.bvalid = 1; axi.bresp = 2'b00;
      @(negedge clk);
      axi.bvalid = 0;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata, axi.bready} !== {2'b10, 32'h0, 1'b0}) begin
         n_fail++; $display("FAIL half_store_resp: got valid/err %b%b rdata %h bready %b expected 10 00000000 0",
            resp_valid, resp_err, resp_rdata, axi.bready);
      end
      consume_resp(rv, rr);
   endtask

   task automatic test_misaligned();
      logic rv, rr;
      @(negedge clk);
      drive_req(1'b0, 32'h8000_0001, 32'h0, SZ_W, 1'b0);
      @(negedge clk);
      req_valid = 0;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata, axi.arvalid, axi.awvalid} !== {2'b11, 32'h0, 2'b00}) begin
         n_fail++; $display("FAIL misaligned_word: got valid/err %b%b rdata %h ar/aw %b%b expected 11 00000000 00",
            resp_valid, resp_err, resp_rdata, axi.arvalid, axi.awvalid);
      end
      consume_resp(rv, rr);
      n_checks++;
      if ({rv, rr, axi.arvalid} !== 3'b010) begin
         n_fail++; $display("FAIL misaligned_release: got valid/ready/arvalid %b expected 010", {rv, rr, axi.arvalid});
      end
      @(negedge clk);
      drive_req(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0);
      @(negedge clk);
      req_valid = 0;
      n_checks++;
      if ({resp_valid, resp_err, axi.arvalid} !== 3'b110) begin
         n_fail++; $display("FAIL illegal_size: got valid/err/arvalid %b expected 110", {resp_valid, resp_err, axi.arvalid});
      end
      consume_resp(rv, rr);
   endtask

   task automatic test_rresp_hold();
      logic [31:0] ar_seen; bit stable, lat, held; logic rv, rr;
      load_txn(32'h8000_0010, SZ_W, 1'b0, 32'h1122_3344, 2'b10, 1, 0, ar_seen, stable, lat);
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) begin
         n_fail++; $display("FAIL rresp_err: got valid/err %b%b rdata %h expected 11 00000000", resp_valid, resp_err, resp_rdata);
      end
      held = 1;
      repeat (5) begin
         @(negedge clk);
         if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) held = 0;
      end
      n_checks++;
      if (held !== 1'b1) begin n_fail++; $display("FAIL rresp_hold: got held %b expected 1", held); end
      consume_resp(rv, rr);
   endtask

   task automatic test_back_to_back();
      logic [31:0] ar_seen; bit stable, lat; logic rv, rr;
      load_txn(32'h8000_0002, SZ_H, 1'b0, 32'h8001_0000, 2'b00, 0, 0, ar_seen, stable, lat);
      n_checks++;
      if (resp_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL b2b_half_load: got %h expected ffff8001", resp_rdata); end
      resp_ready = 1;
      drive_req(1'b1, 32'h8000_0001, 32'h0000_00AB, SZ_B, 1'b0);
      @(negedge clk);
      resp_ready = 0;
      n_checks++;
      if ({resp_valid, req_ready, axi.awvalid} !== 3'b010) begin
         n_fail++; $display("FAIL b2b_idle_gap: got valid/ready/awvalid %b expected 010", {resp_valid, req_ready, axi.awvalid});
      end
      @(negedge clk);
      req_valid = 0;
      n_checks++;
      if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb} !== {2'b11, 32'h8000_0000, 32'h0000_AB00, 4'b0010}) begin
         n_fail++; $display("FAIL b2b_byte_store: got aw/w %b%b awaddr %h wdata %h wstrb %b expected 11 80000000 0000ab00 0010",
            axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb);
      end
      axi.awready = 1; @(negedge clk); axi.awready = 0;
      axi.wready = 1;  @(negedge clk); axi.wready = 0;
      axi.bvalid = 1; axi.bresp = 2'b11;
      @(negedge clk);
      axi.bvalid = 0; axi.bresp = 2'b00;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0}) begin
         n_fail++; $display("FAIL b2b_bresp_err: got valid/err %b%b rdata %h expected 11 00000000", resp_valid, resp_err, resp_rdata);
      end
      consume_resp(rv, rr);
   endtask

   task automatic test_reset_in_b();
      bit saw_resp;
      @(negedge clk);
      drive_req(1'b1, 32'h8000_0020, 32'h55AA_55AA, SZ_W, 1'b0);
      @(negedge clk);
      req_valid = 0;
      axi.awready = 1; axi.wready = 1;
      @(negedge clk);
      axi.awready = 0; axi.wready = 0;
      n_checks++;
      if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
         n_fail++; $display("FAIL same_cycle_aw_w: got aw/w/b %b expected 001", {axi.awvalid, axi.wvalid, axi.bready});
      end
      #2 rst = 1;
      #1;
      n_checks++;
      if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, resp_valid, req_ready} !== 7'b0000001) begin
         n_fail++; $display("FAIL async_reset_outputs: got %b expected 0000001",
            {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, resp_valid, req_ready});
      end
      n_checks++;
      if ({axi.awaddr, axi.wdata, axi.wstrb} !== 68'b0) begin
         n_fail++; $display("FAIL async_reset_data: awaddr %h wdata %h wstrb %b expected 0", axi.awaddr, axi.wdata, axi.wstrb);
      end
      axi.bvalid = 1;
      @(negedge clk);
      rst = 0;
      saw_resp = 0;
      repeat (5) begin
         @(negedge clk);
         axi.bvalid = 0;
         if (resp_valid !== 1'b0) saw_resp = 1;
      end
      n_checks++;
      if ({saw_resp, req_ready} !== 2'b01) begin
         n_fail++; $display("FAIL reset_abandon: got saw_resp/req_ready %b%b expected 01", saw_resp, req_ready);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 0;
      test_word_load();
      test_byte_load();
      test_half_store();
      test_misaligned();
      test_rresp_hold();
      test_back_to_back();
      test_reset_in_b();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
